uart_tx_mmio: RTL

Memory-mapped UART transmitter sitting on the CPU/RAM data bus as a peripheral slave, selected by a top-level address decode. It consumes CPU store cycles, buffers bytes in a small FIFO and serialises them 8N1 on a single `tx` pin. CPU loads return status and divisor registers with one-cycle latency, matching RAM read timing.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_mmio.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared register map, status layout and TX state encoding for the MMIO UART transmitter.
package uart_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // A programmed divisor of zero would stall the baud counter, so it behaves as one.
    function automatic logic [15:0] effDivisor(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             pushOk;
    logic             popOk;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign popOk   = pop && !empty;
    assign pushOk  = push && (!full || popOk);
    assign popData = mem[rdPtr];

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + CW'(pushOk) - CW'(popOk);
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, control registers, TX FIFO and serialiser FSM.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit, line low for div cycles
//   DATA  | 8 data bits LSB first, div cycles each
//   STOP  | stop bit, line high; chains straight into START if more data is queued
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    input  logic        memWrite,
    input  logic [3:0]  byteMask,
    output logic [31:0] memReadData,
    output logic        tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    regAddr;
    logic          busWr;
    logic          busRd;
    logic          pushReq;
    logic          popReq;
    logic [7:0]    fifoHead;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    logic [15:0]   divisor;
    logic          overflow;
    logic [3:0]    countSat;
    logic [31:0]   statusWord;
    logic [31:0]   readMux;
    logic          unusedBits;

    tx_state_t   state, stateNext;
    logic [7:0]  shifter, shifterNext;
    logic [2:0]  bitCnt, bitCntNext;
    logic [15:0] baudCnt, baudCntNext;
    logic [15:0] divLatched, divLatchedNext;
    logic        txNext;
    logic        loadFrame;

    assign regAddr    = memAddress[3:2];
    assign busWr      = sel && memWrite;
    assign busRd      = sel && !memWrite;
    assign pushReq    = busWr && (regAddr == REG_DATA) && byteMask[0];
    assign countSat   = (32'(fifoCount) > 32'd15) ? 4'd15 : 4'(fifoCount);
    assign unusedBits = ^{memAddress[31:4], memAddress[1:0], memWriteData[31:16], byteMask[3:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (pushReq),
        .pushData (memWriteData[7:0]),
        .pop      (popReq),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // Assemble the STATUS word and select load data by register offset.
    always_comb begin
        statusWord                            = '0;
        statusWord[STAT_BUSY]                 = (state != IDLE);
        statusWord[STAT_FULL]                 = fifoFull;
        statusWord[STAT_EMPTY]                = fifoEmpty;
        statusWord[STAT_OVERFLOW]             = overflow;
        statusWord[STAT_COUNT_LSB +: 4]       = countSat;
        readMux                               = '0;
        case (regAddr)
            REG_STATUS:  readMux = statusWord;
            REG_DIVISOR: readMux = {16'b0, divisor};
            default:     readMux = '0;
        endcase
    end

    // Control registers: per-byte divisor stores and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor  <= 16'(CLKS_PER_BIT);
            overflow <= 1'b0;
        end else begin
            if (busWr && (regAddr == REG_DIVISOR)) begin
                if (byteMask[0]) divisor[7:0]  <= memWriteData[7:0];
                if (byteMask[1]) divisor[15:8] <= memWriteData[15:8];
            end
            if (pushReq && fifoFull && !popReq) begin
                overflow <= 1'b1;
            end else if (busWr && (regAddr == REG_STATUS) && byteMask[0]
                         && memWriteData[STAT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Load data is captured on read cycles only and held otherwise, like a RAM read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memReadData <= '0;
        end else if (busRd) begin
            memReadData <= readMux;
        end
    end

    // Serialiser next-state: baud down-counter reloads with div-1 at each bit boundary.
    always_comb begin
        stateNext      = state;
        shifterNext    = shifter;
        bitCntNext     = bitCnt;
        baudCntNext    = baudCnt;
        divLatchedNext = divLatched;
        popReq         = 1'b0;
        loadFrame      = 1'b0;
        case (state)
            IDLE: begin
                loadFrame = !fifoEmpty;
            end
            START: begin
                if (baudCnt == 16'd0) begin
                    baudCntNext = divLatched - 16'd1;
                    bitCntNext  = 3'd0;
                    stateNext   = DATA;
                end else begin
                    baudCntNext = baudCnt - 16'd1;
                end
            end
            DATA: begin
                if (baudCnt == 16'd0) begin
                    baudCntNext = divLatched - 16'd1;
                    shifterNext = {1'b0, shifter[7:1]};
                    bitCntNext  = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        stateNext = STOP;
                    end
                end else begin
                    baudCntNext = baudCnt - 16'd1;
                end
            end
            STOP: begin
                if (baudCnt == 16'd0) begin
                    loadFrame = !fifoEmpty;
                    stateNext = IDLE;
                end else begin
                    baudCntNext = baudCnt - 16'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
        // The divisor is sampled at the pop so mid-frame writes only affect the next frame.
        if (loadFrame) begin
            popReq         = 1'b1;
            shifterNext    = fifoHead;
            divLatchedNext = effDivisor(divisor);
            baudCntNext    = effDivisor(divisor) - 16'd1;
            stateNext      = START;
        end
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shifterNext[0];
            default: txNext = 1'b1;
        endcase
    end

    // Serialiser registers; tx is registered alongside the state so it changes on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shifter    <= '0;
            bitCnt     <= '0;
            baudCnt    <= '0;
            divLatched <= 16'd1;
            tx         <= 1'b1;
        end else begin
            state      <= stateNext;
            shifter    <= shifterNext;
            bitCnt     <= bitCntNext;
            baudCnt    <= baudCntNext;
            divLatched <= divLatchedNext;
            tx         <= txNext;
        end
    end

endmodule
